// File: rtl/bridge_seq_pkg.sv
// Shared command, state and gate-pattern types for the H-bridge command sequencer.
package bridge_seq_pkg;

  typedef enum logic [2:0] {
    PAUSE     = 3'd0,
    PLUS      = 3'd1,
    MINUS     = 3'd2,
    BAL_P     = 3'd3,
    BAL_N     = 3'd4,
    START     = 3'd5,
    SHUTDOWN  = 3'd6,
    DISCHARGE = 3'd7
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_D0,
    S_D1,
    S_D2,
    S_D3,
    S_FAULT
  } dec_state_t;

  typedef enum logic [1:0] {
    SQ_OFF,
    SQ_PRE,
    SQ_SET
  } seq_state_t;

  typedef struct packed {
    logic [3:0] top;
    logic [3:0] bot;
    logic [3:0] mode;
  } bridge_pat_t;

  localparam bridge_pat_t PAT_OFF   = '{top: 4'b0000, bot: 4'b0000, mode: 4'b0000};
  localparam bridge_pat_t PAT_PLUS  = '{top: 4'b0001, bot: 4'b0010, mode: 4'b0001};
  localparam bridge_pat_t PAT_MINUS = '{top: 4'b0010, bot: 4'b0001, mode: 4'b0010};
  localparam bridge_pat_t PAT_BAL_P = '{top: 4'b0100, bot: 4'b1000, mode: 4'b0100};
  localparam bridge_pat_t PAT_BAL_N = '{top: 4'b1000, bot: 4'b0100, mode: 4'b1000};
  localparam bridge_pat_t PAT_DIS1  = '{top: 4'b0001, bot: 4'b0010, mode: 4'b0001};
  localparam bridge_pat_t PAT_DIS3  = '{top: 4'b0100, bot: 4'b1000, mode: 4'b0001};

  function automatic bridge_pat_t drive_pat(input cmd_t c);
    case (c)
      PLUS:    return PAT_PLUS;
      MINUS:   return PAT_MINUS;
      BAL_P:   return PAT_BAL_P;
      BAL_N:   return PAT_BAL_N;
      default: return PAT_OFF;
    endcase
  endfunction

  // Counter width able to hold max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bridge_deadtime.sv
// Dead-time gate: blanks the bridge for DEADTIME+1 cycles before a requested pattern is driven.
module bridge_deadtime
  import bridge_seq_pkg::*;
#(
  parameter int DEADTIME = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  bridge_pat_t req_pat,
  input  logic        cancel,
  output bridge_pat_t pat,
  output logic        pending
);

  localparam int DW = cnt_width(DEADTIME);

  logic [DW-1:0] dt;
  bridge_pat_t   target;

  // Cancel beats a new request so fault and watchdog blanking can never be overridden.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pat     <= PAT_OFF;
      pending <= 1'b0;
      dt      <= '0;
      target  <= PAT_OFF;
    end else if (cancel) begin
      pat     <= PAT_OFF;
      pending <= 1'b0;
      dt      <= '0;
    end else if (req) begin
      pat     <= PAT_OFF;
      pending <= 1'b1;
      dt      <= DW'(DEADTIME);
      target  <= req_pat;
    end else if (pending) begin
      if (dt == '0) begin
        pat     <= target;
        pending <= 1'b0;
      end else begin
        dt <= dt - DW'(1);
      end
    end
  end

endmodule

// File: rtl/bridge_seq_ctrl.sv
// H-bridge command sequencer: strobe-driven command decode, precharge/discharge sequencing,
// fault latching with guarded clear, and an idle-bridge watchdog.
module bridge_seq_ctrl
  import bridge_seq_pkg::*;
#(
  parameter int DEADTIME      = 4,
  parameter int PRECHARGE_CYC = 750000000,
  parameter int SETTLE_CYC    = 50000000,
  parameter int WDT_CYC       = 0,
  parameter int NUM_ERR       = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               strobe_i,
  input  logic [2:0]         cmd_i,
  input  logic [NUM_ERR-1:0] err_i,
  output logic [3:0]         top_o,
  output logic [3:0]         bot_o,
  output logic [3:0]         mode_o,
  output logic               st_o,
  output logic               ch_o,
  output logic               fan_o,
  output logic               break_o,
  output logic [NUM_ERR-1:0] err_latch_o,
  output logic               idle_o,
  output logic               wdt_trip_o
);

  localparam int TMAX = (PRECHARGE_CYC > SETTLE_CYC) ? PRECHARGE_CYC : SETTLE_CYC;
  localparam int TW   = cnt_width(TMAX);
  localparam int WW   = cnt_width(WDT_CYC);

  localparam logic [TW-1:0] PRE_LOAD = TW'(PRECHARGE_CYC - 1);
  localparam logic [TW-1:0] SET_LOAD = TW'(SETTLE_CYC - 1);
  localparam logic [WW-1:0] WDT_LOAD = WW'((WDT_CYC > 0) ? WDT_CYC - 1 : 0);

  typedef struct packed {
    dec_state_t         dec;
    seq_state_t         sq;
    logic [TW-1:0]      timer;
    logic [WW-1:0]      wdt;
    logic [1:0]         clr_step;
    logic               strobe_q;
    logic               cmd_vld;
    cmd_t               cmd_q;
    logic               st;
    logic               ch;
    logic               fan;
    logic               brk;
    logic               wdt_trip;
    logic               idle;
    logic [NUM_ERR-1:0] err_latch;
  } ctrl_t;

  ctrl_t       r;
  ctrl_t       nxt;
  logic        fall;
  logic        dt_req;
  logic        dt_cancel;
  logic        pending;
  bridge_pat_t dt_req_pat;
  bridge_pat_t pat;

  bridge_deadtime #(
    .DEADTIME (DEADTIME)
  ) u_deadtime (
    .clk     (clk),
    .rstn    (rstn),
    .req     (dt_req),
    .req_pat (dt_req_pat),
    .cancel  (dt_cancel),
    .pat     (pat),
    .pending (pending)
  );

  always_comb begin
    nxt        = r;
    dt_req     = 1'b0;
    dt_req_pat = PAT_OFF;
    dt_cancel  = 1'b0;

    // Command is captured on the strobe's falling edge and decoded one cycle later.
    fall         = r.strobe_q & ~strobe_i;
    nxt.strobe_q = strobe_i;
    nxt.cmd_vld  = fall;
    if (fall) nxt.cmd_q = cmd_t'(cmd_i);

    case (r.sq)
      SQ_PRE: begin
        if (r.timer == '0) begin
          nxt.st    = 1'b1;
          nxt.sq    = SQ_SET;
          nxt.timer = SET_LOAD;
        end else begin
          nxt.timer = r.timer - TW'(1);
        end
      end
      SQ_SET: begin
        if (r.timer == '0) begin
          nxt.ch = 1'b0;
          nxt.sq = SQ_OFF;
        end else begin
          nxt.timer = r.timer - TW'(1);
        end
      end
      default: ;
    endcase

    // PAUSE and SHUTDOWN stay effective while a pattern change is pending; they only blank.
    if (r.cmd_vld) begin
      case (r.dec)
        S_IDLE: begin
          case (r.cmd_q)
            PAUSE: dt_cancel = 1'b1;
            PLUS, MINUS, BAL_P, BAL_N: begin
              if (r.sq == SQ_OFF && r.st && !r.ch && !pending) begin
                dt_req     = 1'b1;
                dt_req_pat = drive_pat(r.cmd_q);
              end
            end
            START: begin
              if (r.sq == SQ_OFF && !pending) nxt.dec = S_START;
            end
            SHUTDOWN: begin
              dt_cancel = 1'b1;
              nxt.st    = 1'b0;
              nxt.ch    = 1'b0;
              nxt.fan   = 1'b0;
              nxt.sq    = SQ_OFF;
              nxt.timer = '0;
            end
            DISCHARGE: begin
              if (r.sq == SQ_OFF && !pending) nxt.dec = S_D0;
            end
            default: ;
          endcase
        end
        S_START: begin
          if (r.cmd_q == PAUSE) begin
            dt_cancel = 1'b1;
            nxt.fan   = 1'b1;
            nxt.st    = 1'b0;
            nxt.ch    = 1'b1;
            nxt.sq    = SQ_PRE;
            nxt.timer = PRE_LOAD;
          end
          nxt.dec = S_IDLE;
        end
        S_D0: nxt.dec = (r.cmd_q == PAUSE)     ? S_D1 : S_IDLE;
        S_D1: nxt.dec = (r.cmd_q == DISCHARGE) ? S_D2 : S_IDLE;
        S_D2: nxt.dec = (r.cmd_q == PAUSE)     ? S_D3 : S_IDLE;
        S_D3: begin
          // Codes 1 and 3 select the single- and triple-leg discharge patterns.
          if (r.st || r.ch) begin
            nxt.dec = S_IDLE;
          end else if (r.cmd_q == PLUS) begin
            dt_req     = 1'b1;
            dt_req_pat = PAT_DIS1;
            nxt.dec    = S_IDLE;
          end else if (r.cmd_q == BAL_P) begin
            dt_req     = 1'b1;
            dt_req_pat = PAT_DIS3;
            nxt.dec    = S_IDLE;
          end
        end
        S_FAULT: begin
          if (r.cmd_q == DISCHARGE) begin
            nxt.clr_step = 2'd1;
          end else if (r.clr_step == 2'd1 && r.cmd_q == PAUSE) begin
            nxt.clr_step = 2'd2;
          end else if (r.clr_step == 2'd2 && r.cmd_q == SHUTDOWN && err_i == '0) begin
            nxt.clr_step  = 2'd0;
            nxt.err_latch = '0;
            nxt.brk       = 1'b0;
            nxt.wdt_trip  = 1'b0;
            nxt.dec       = S_IDLE;
          end else begin
            nxt.clr_step = 2'd0;
          end
        end
        default: nxt.dec = S_IDLE;
      endcase
    end

    // With WDT_CYC == 0 the counter is pinned at zero and never fires.
    if (fall || pat.top == 4'b0000) begin
      nxt.wdt = WDT_LOAD;
    end else if (r.wdt == '0) begin
      if (WDT_CYC > 0) begin
        dt_cancel    = 1'b1;
        nxt.wdt_trip = 1'b1;
      end
    end else begin
      nxt.wdt = r.wdt - WW'(1);
    end

    if (|err_i) begin
      nxt.dec       = S_FAULT;
      dt_cancel     = 1'b1;
      nxt.st        = 1'b0;
      nxt.ch        = 1'b0;
      nxt.fan       = 1'b1;
      nxt.brk       = 1'b1;
      nxt.sq        = SQ_OFF;
      nxt.timer     = '0;
      nxt.err_latch = r.err_latch | err_i;
      nxt.clr_step  = 2'd0;
    end

    // Registered so that idle_o is low while reset is held, like every other output.
    nxt.idle = (nxt.dec == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) r <= '0;
    else       r <= nxt;
  end

  assign top_o       = pat.top;
  assign bot_o       = pat.bot;
  assign mode_o      = pat.mode;
  assign st_o        = r.st;
  assign ch_o        = r.ch;
  assign fan_o       = r.fan;
  assign break_o     = r.brk;
  assign err_latch_o = r.err_latch;
  assign idle_o      = r.idle;
  assign wdt_trip_o  = r.wdt_trip;

endmodule

// File: tb/tb_bridge_seq_ctrl.sv
// Self-checking bench for bridge_seq_ctrl: directed scenarios plus random strobes against an event-time model.
module tb_bridge_seq_ctrl;

  localparam int DEADTIME = 4;
  localparam int PRE      = 150;
  localparam int SET      = 10;
  localparam int WDT      = 100;
  localparam int NERR     = 8;

  localparam int M_IDLE  = 0;
  localparam int M_START = 1;
  localparam int M_D0    = 2;
  localparam int M_D1    = 3;
  localparam int M_D2    = 4;
  localparam int M_D3    = 5;
  localparam int M_FAULT = 6;

  logic            clk = 1'b0;
  logic            rstn;
  logic            strobe;
  logic [2:0]      cmd;
  logic [NERR-1:0] err;
  logic [3:0]      top_o, bot_o, mode_o;
  logic            st_o, ch_o, fan_o, break_o, idle_o, wdt_trip_o;
  logic [NERR-1:0] err_latch_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: bridge pattern changes and sequencer steps are scheduled as absolute edge numbers.
  int            n;
  int            m_state;
  logic [11:0]   m_pat, m_next;
  int            m_show_at;
  logic          m_st, m_ch, m_fan, m_brk, m_trip, m_idle;
  logic [NERR-1:0] m_err;
  int            m_st_at, m_choff_at;
  int            m_last_quiet;
  int            m_clr;
  logic          m_strobe_q, m_vld;
  int            m_cmd;

  always #5 clk = ~clk;

  bridge_seq_ctrl #(
    .DEADTIME      (DEADTIME),
    .PRECHARGE_CYC (PRE),
    .SETTLE_CYC    (SET),
    .WDT_CYC       (WDT),
    .NUM_ERR       (NERR)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .strobe_i    (strobe),
    .cmd_i       (cmd),
    .err_i       (err),
    .top_o       (top_o),
    .bot_o       (bot_o),
    .mode_o      (mode_o),
    .st_o        (st_o),
    .ch_o        (ch_o),
    .fan_o       (fan_o),
    .break_o     (break_o),
    .err_latch_o (err_latch_o),
    .idle_o      (idle_o),
    .wdt_trip_o  (wdt_trip_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at edge %0d: got %h expected %h", tag, n, act, exp);
    end
  endtask

  function automatic logic [11:0] patOf(input int c);
    case (c)
      1:       return 12'h121;
      2:       return 12'h212;
      3:       return 12'h484;
      4:       return 12'h848;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [31:0] dutVec();
    return {top_o, bot_o, mode_o, st_o, ch_o, fan_o, break_o, err_latch_o, idle_o, wdt_trip_o, 6'b0};
  endfunction

  function automatic logic [31:0] modelVec();
    return {m_pat, m_st, m_ch, m_fan, m_brk, m_err, m_idle, m_trip, 6'b0};
  endfunction

  task automatic modelReset();
    m_state = M_IDLE; m_pat = '0; m_next = '0; m_show_at = -1;
    m_st = 0; m_ch = 0; m_fan = 0; m_brk = 0; m_trip = 0; m_idle = 0;
    m_err = '0; m_st_at = -1; m_choff_at = -1; m_last_quiet = n;
    m_clr = 0; m_strobe_q = 0; m_vld = 0; m_cmd = 0;
  endtask

  task automatic modelRequest(input logic [11:0] p);
    m_pat = '0; m_next = p; m_show_at = n + DEADTIME + 1;
  endtask

  task automatic modelBlank();
    m_pat = '0; m_show_at = -1;
  endtask

  task automatic modelDecode(input int c, input bit pend, input bit busy, input bit pst, input bit pch);
    case (m_state)
      M_IDLE: begin
        if (c == 0) modelBlank();
        else if (c <= 4) begin
          if (!busy && pst && !pch && !pend) modelRequest(patOf(c));
        end else if (c == 5) begin
          if (!busy && !pend) m_state = M_START;
        end else if (c == 6) begin
          modelBlank(); m_st = 0; m_ch = 0; m_fan = 0; m_st_at = -1; m_choff_at = -1;
        end else begin
          if (!busy && !pend) m_state = M_D0;
        end
      end
      M_START: begin
        if (c == 0) begin
          modelBlank(); m_fan = 1; m_st = 0; m_ch = 1;
          m_st_at = n + PRE; m_choff_at = n + PRE + SET;
        end
        m_state = M_IDLE;
      end
      M_D0: m_state = (c == 0) ? M_D1 : M_IDLE;
      M_D1: m_state = (c == 7) ? M_D2 : M_IDLE;
      M_D2: m_state = (c == 0) ? M_D3 : M_IDLE;
      M_D3: begin
        if (pst || pch) m_state = M_IDLE;
        else if (c == 1) begin modelRequest(12'h121); m_state = M_IDLE; end
        else if (c == 3) begin modelRequest(12'h481); m_state = M_IDLE; end
      end
      default: begin
        if (c == 7) m_clr = 1;
        else if (m_clr == 1 && c == 0) m_clr = 2;
        else if (m_clr == 2 && c == 6 && err == '0) begin
          m_clr = 0; m_err = '0; m_brk = 0; m_trip = 0; m_state = M_IDLE;
        end else m_clr = 0;
      end
    endcase
  endtask

  // Advances the model across the coming clock edge using the inputs currently driven.
  task automatic modelEdge();
    bit          pend, busy, pst, pch, fall, dvld;
    int          dcmd;
    logic [11:0] ppat;
    n++;
    if (!rstn) begin
      modelReset();
      return;
    end
    pend = (m_show_at >= 0); busy = (m_choff_at >= 0); pst = m_st; pch = m_ch; ppat = m_pat;
    fall = m_strobe_q && !strobe;
    dvld = m_vld; dcmd = m_cmd;
    m_vld = fall;
    if (fall) m_cmd = int'(cmd);
    m_strobe_q = strobe;
    if (pend && n == m_show_at) begin m_pat = m_next; m_show_at = -1; end
    if (m_st_at == n)    begin m_st = 1; m_st_at = -1; end
    if (m_choff_at == n) begin m_ch = 0; m_choff_at = -1; end
    if (dvld) modelDecode(dcmd, pend, busy, pst, pch);
    if (fall || ppat[11:8] == 4'b0) m_last_quiet = n;
    else if (n - m_last_quiet >= WDT) begin modelBlank(); m_trip = 1; end
    if (err != '0) begin
      m_state = M_FAULT; modelBlank(); m_st = 0; m_ch = 0; m_fan = 1; m_brk = 1;
      m_st_at = -1; m_choff_at = -1; m_err = m_err | err; m_clr = 0;
    end
    m_idle = (m_state == M_IDLE);
  endtask

  task automatic clockCycle();
    modelEdge();
    @(posedge clk);
    @(negedge clk);
    checkOutput("cycle", dutVec(), modelVec());
  endtask

  task automatic runCycles(input int k);
    repeat (k) clockCycle();
  endtask

  task automatic applyStimulus(input logic [2:0] c, input int hold);
    cmd = c; strobe = 1'b1; clockCycle();
    strobe = 1'b0; clockCycle();
    runCycles(hold);
  endtask

  initial begin
    int r;
    rstn = 1'b0; strobe = 1'b0; cmd = 3'd0; err = '0; n = 0;
    modelReset();
    runCycles(2);
    checkOutput("reset", dutVec(), 32'h0);
    rstn = 1'b1;
    clockCycle();
    checkOutput("idle_after_reset", {31'b0, idle_o}, 32'd1);

    // Precharge: START then 0
    applyStimulus(3'd5, 0); applyStimulus(3'd0, 0); clockCycle();
    checkOutput("precharge_start", {29'b0, fan_o, ch_o, st_o}, 32'b110);
    runCycles(149);
    checkOutput("st_before", {31'b0, st_o}, 32'd0);
    clockCycle();
    checkOutput("st_on", {30'b0, st_o, ch_o}, 32'b11);
    runCycles(9);
    checkOutput("ch_before", {31'b0, ch_o}, 32'd1);
    clockCycle();
    checkOutput("ch_off", {30'b0, st_o, ch_o}, 32'b10);

    // PLUS with a MINUS arriving during the dead-time gap
    applyStimulus(3'd1, 0); applyStimulus(3'd2, 0);
    runCycles(3);
    checkOutput("gap_end", {20'b0, top_o, bot_o, mode_o}, 32'h0);
    clockCycle();
    checkOutput("plus_pattern", {20'b0, top_o, bot_o, mode_o}, 32'h121);

    // Watchdog expiry with no strobes, then re-arm
    runCycles(99);
    checkOutput("wdt_hold", {27'b0, top_o, wdt_trip_o}, 32'b00010);
    clockCycle();
    checkOutput("wdt_fire", {27'b0, top_o, wdt_trip_o}, 32'b00001);
    applyStimulus(3'd1, 0); runCycles(6);
    checkOutput("plus_after_wdt", {19'b0, top_o, bot_o, mode_o, wdt_trip_o}, {19'b0, 12'h121, 1'b1});

    // Fault during PLUS and the guarded clear
    err = 8'h04; clockCycle(); err = '0;
    checkOutput("fault_entry", {16'b0, top_o, st_o, ch_o, break_o, idle_o, err_latch_o},
                {16'b0, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h04});
    applyStimulus(3'd7, 0); applyStimulus(3'd0, 0); applyStimulus(3'd6, 0); clockCycle();
    checkOutput("fault_clear", {19'b0, break_o, err_latch_o, wdt_trip_o, idle_o, fan_o},
                {19'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1});
    err = 8'h01; clockCycle();
    applyStimulus(3'd7, 0); applyStimulus(3'd0, 0); applyStimulus(3'd6, 0); clockCycle();
    checkOutput("clear_blocked", {22'b0, idle_o, break_o, err_latch_o}, {22'b0, 1'b0, 1'b1, 8'h01});
    err = '0; clockCycle();
    applyStimulus(3'd7, 0); applyStimulus(3'd0, 0); applyStimulus(3'd6, 0); clockCycle();
    checkOutput("clear_after_release", {22'b0, idle_o, break_o, err_latch_o}, {22'b0, 1'b1, 1'b0, 8'h00});

    // Discharge chain selecting DIS3, then an aborted chain
    applyStimulus(3'd7, 0); applyStimulus(3'd0, 0); applyStimulus(3'd7, 0); applyStimulus(3'd0, 0);
    applyStimulus(3'd3, 0); runCycles(5);
    checkOutput("dis3_gap", {20'b0, top_o, bot_o, mode_o}, 32'h0);
    clockCycle();
    checkOutput("dis3_pattern", {20'b0, top_o, bot_o, mode_o}, 32'h481);
    applyStimulus(3'd7, 0); applyStimulus(3'd0, 0); applyStimulus(3'd5, 0); runCycles(4);
    checkOutput("no_effect", {19'b0, idle_o, top_o, bot_o, mode_o}, {19'b0, 1'b1, 12'h481});
    applyStimulus(3'd6, 1);
    checkOutput("shutdown", {25'b0, fan_o, st_o, ch_o, top_o}, 32'h0);

    // Reset in the middle of precharge
    applyStimulus(3'd5, 0); applyStimulus(3'd0, 50);
    rstn = 1'b0; clockCycle();
    checkOutput("reset_mid", dutVec(), 32'h0);
    rstn = 1'b1;
    applyStimulus(3'd1, 10);
    checkOutput("plus_ignored", {28'b0, top_o}, 32'h0);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        err = NERR'($urandom_range(1, 255)); clockCycle(); err = '0; clockCycle();
      end else if (r == 4) begin
        rstn = 1'b0; clockCycle(); rstn = 1'b1; clockCycle();
      end else if (m_state == M_FAULT && r < 60) begin
        applyStimulus(3'd7, 0); applyStimulus(3'd0, 0); applyStimulus(3'd6, 1);
      end else if (r < 12 && m_choff_at < 0 && !m_st) begin
        applyStimulus(3'd5, 0); applyStimulus(3'd0, int'($urandom_range(0, 170)));
      end else if (r < 15) begin
        applyStimulus(3'd1, int'($urandom_range(100, 120)));
      end else begin
        applyStimulus(3'($urandom_range(0, 7)), int'($urandom_range(0, 8)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
